// File: rtl/cpu_run_controller_if.sv
// Run-controller handshake bundle: start/halt in, CPU control and status out.
// Optional halt log signals exist only with RUN_CTRL_HALT_LOG_EN defined.
interface cpu_run_controller_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             cpu_halt;
  logic             cpu_reset;
  logic             cpu_en;
  logic [CNT_W-1:0] cycle_count;
  logic [7:0]       run_index;
  logic             busy;
  logic             done;
  logic             timeout;
`ifdef RUN_CTRL_HALT_LOG_EN
  logic [7:0]       halt_runs;
  logic [CNT_W-1:0] last_len;
`endif

  modport master (
    input  start, cpu_halt,
`ifdef RUN_CTRL_HALT_LOG_EN
    output halt_runs, last_len,
`endif
    output cpu_reset, cpu_en, cycle_count,
    output run_index, busy, done, timeout
  );

  modport slave (
    output start, cpu_halt,
`ifdef RUN_CTRL_HALT_LOG_EN
    input  halt_runs, last_len,
`endif
    input  cpu_reset, cpu_en, cycle_count,
    input  run_index, busy, done, timeout
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Reset/run sequencer for the CPU datapath: RST phase, budgeted RUN, repeat.
// Optional halt log (halt_runs, last_len) enabled by RUN_CTRL_HALT_LOG_EN.
module cpu_run_controller #(
  parameter int RESET_CYCLES = 2,
  parameter int RUN_CYCLES   = 70,
  parameter int RUNS         = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_run_controller_if.master bus
);

  localparam int RW =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST =
    RW'(RESET_CYCLES - 1);
  localparam logic [7:0] RUN_LAST = 8'(RUNS - 1);
  localparam logic [CNT_W-1:0] BUD_LAST =
    CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit LIMITED = (RUN_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic             tout_q, tout_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             cpu_en_q, cpu_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef RUN_CTRL_HALT_LOG_EN
  logic [7:0]       halt_runs_q, halt_runs_d;
  logic [CNT_W-1:0] last_len_q, last_len_d;
`endif

  logic [CNT_W-1:0] cnt_inc;
  logic             budget_hit;
  logic             run_end;

  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ?
      cnt_q : cnt_q + CNT_W'(1);
    budget_hit = LIMITED && (cnt_q == BUD_LAST);
    run_end = bus.cpu_halt | budget_hit;
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tout_d    = tout_q;
`ifdef RUN_CTRL_HALT_LOG_EN
    halt_runs_d = halt_runs_q;
    last_len_d  = last_len_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_RST;
          rst_cnt_d = '0;
          cnt_d     = '0;
          idx_d     = '0;
          tout_d    = 1'b0;
`ifdef RUN_CTRL_HALT_LOG_EN
          halt_runs_d = '0;
`endif
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (run_end) begin
          // halt beats a same-edge budget expiry
          tout_d = tout_q | (budget_hit & ~bus.cpu_halt);
`ifdef RUN_CTRL_HALT_LOG_EN
          last_len_d = cnt_inc;
          if (bus.cpu_halt) begin
            halt_runs_d = halt_runs_q + 8'd1;
          end
`endif
          if (idx_q == RUN_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RST;
            idx_d     = idx_q + 8'd1;
            cnt_d     = '0;
            rst_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_reset_d = (state_d == S_IDLE) ||
                  (state_d == S_RST);
    cpu_en_d    = (state_d == S_RUN);
    busy_d      = (state_d == S_RST) ||
                  (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tout_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RUN_CTRL_HALT_LOG_EN
      halt_runs_q <= '0;
      last_len_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tout_q      <= tout_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef RUN_CTRL_HALT_LOG_EN
      halt_runs_q <= halt_runs_d;
      last_len_q  <= last_len_d;
`endif
    end
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.cpu_en      = cpu_en_q;
  assign bus.cycle_count = cnt_q;
  assign bus.run_index   = idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = tout_q;
`ifdef RUN_CTRL_HALT_LOG_EN
  assign bus.halt_runs   = halt_runs_q;
  assign bus.last_len    = last_len_q;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench: planned run lengths expand into per-cycle expected output.
// Second instance covers unlimited-budget saturation with a 4-bit counter.
module tb_cpu_run_controller;

  localparam int RC  = 2;
  localparam int BUD = 70;
  localparam int NR  = 3;

  typedef struct packed {
    logic        rs;
    logic        en;
    logic        bz;
    logic        dn;
    logic        to;
    logic [15:0] cc;
    logic [7:0]  ri;
    logic [7:0]  hr;
    logic [15:0] ll;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  always #5 clk = ~clk;

  cpu_run_controller_if #(.CNT_W(16)) m_if ();
  cpu_run_controller_if #(.CNT_W(4))  s_if ();

  cpu_run_controller #(
    .RESET_CYCLES(RC), .RUN_CYCLES(BUD),
    .RUNS(NR), .CNT_W(16)
  ) u_dut (
    .clk(clk), .reset(rst), .bus(m_if)
  );

  cpu_run_controller #(
    .RESET_CYCLES(RC), .RUN_CYCLES(0),
    .RUNS(1), .CNT_W(4)
  ) u_sat (
    .clk(clk), .reset(rst_s), .bus(s_if)
  );

  exp_t q[$];
  exp_t q_s[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_main  = 0;
  int   n_sat   = 0;

  // reference model state: sticky timeout, halt tally, last run length
  bit   m_to;
  int   m_hr;
  int   m_ll;
  int   plan[NR];

  function automatic exp_t mk(
    logic rs, logic en, logic bz, logic dn, logic to,
    int cc, int ri, int hr, int ll);
    exp_t e;
    e.rs = rs; e.en = en; e.bz = bz;
    e.dn = dn; e.to = to;
    e.cc = 16'(cc); e.ri = 8'(ri);
    e.hr = 8'(hr); e.ll = 16'(ll);
    return e;
  endfunction

  function automatic exp_t idle_r();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t rst_r(int r);
    return mk(1, 0, 1, 0, m_to, 0, r, m_hr, m_ll);
  endfunction

  function automatic exp_t run_r(int r, int k);
    return mk(0, 1, 1, 0, m_to, k, r, m_hr, m_ll);
  endfunction

  function automatic exp_t done_r(int cc, int r);
    return mk(0, 0, 0, 1, m_to, cc, r, m_hr, m_ll);
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void check(
    string nm, int idx, exp_t a, exp_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display({"FAIL %s[%0d] got rs=%b en=%b bz=%b dn=%b",
        " to=%b cc=%0d ri=%0d hr=%0d ll=%0d | want rs=%b",
        " en=%b bz=%b dn=%b to=%b cc=%0d ri=%0d hr=%0d ll=%0d"},
        nm, idx, a.rs, a.en, a.bz, a.dn, a.to, a.cc, a.ri,
        a.hr, a.ll, e.rs, e.en, e.bz, e.dn, e.to, e.cc,
        e.ri, e.hr, e.ll);
    end
  endfunction

  task automatic edge_m(bit st, bit h, bit r, exp_t e);
    m_if.start    = st;
    m_if.cpu_halt = h;
    rst           = r;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic edge_s(bit st, bit h, bit r, exp_t e);
    s_if.start    = st;
    s_if.cpu_halt = h;
    rst_s         = r;
    @(posedge clk);
    q_s.push_back(e);
    #1;
  endtask

  task automatic abort_edge();
    m_to = 0; m_hr = 0; m_ll = 0;
    edge_m(1, 1, 1, idle_r());
    repeat (3) edge_m(0, rb(), 0, idle_r());
  endtask

  // plan[r]: RUN edge (1-based) on which halt is sampled, 0 = never
  task automatic run_sequence(int abort_cc);
    int  len;
    bit  halted;
    m_to = 0;
    m_hr = 0;
    edge_m(1, rb(), 0, rst_r(0));
    for (int r = 0; r < NR; r++) begin
      for (int k = 1; k < RC; k++)
        edge_m(rb(), rb(), 0, rst_r(r));
      edge_m(rb(), rb(), 0, run_r(r, 0));
      halted = plan[r] >= 1 && plan[r] <= BUD;
      len = halted ? plan[r] : BUD;
      for (int k = 1; k < len; k++) begin
        if (r == 0 && k - 1 == abort_cc) begin
          abort_edge();
          return;
        end
        edge_m(rb(), 0, 0, run_r(r, k));
      end
      if (r == 0 && len - 1 == abort_cc) begin
        abort_edge();
        return;
      end
      m_to = m_to | !halted;
      if (halted) m_hr++;
      m_ll = len;
      if (r == NR - 1)
        edge_m(rb(), halted, 0, done_r(len, r));
      else
        edge_m(rb(), halted, 0, rst_r(r + 1));
    end
    repeat (3) edge_m(0, rb(), 0, done_r(len, NR - 1));
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '0;
      a.rs = m_if.cpu_reset; a.en = m_if.cpu_en;
      a.bz = m_if.busy;      a.dn = m_if.done;
      a.to = m_if.timeout;
      a.cc = m_if.cycle_count;
      a.ri = m_if.run_index;
`ifdef RUN_CTRL_HALT_LOG_EN
      a.hr = m_if.halt_runs;
      a.ll = m_if.last_len;
`else
      e.hr = '0; e.ll = '0;
`endif
      check("main", n_main, a, e);
      n_main++;
    end
  end

  always @(negedge clk) begin
    exp_t a, e;
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      a = '0;
      a.rs = s_if.cpu_reset; a.en = s_if.cpu_en;
      a.bz = s_if.busy;      a.dn = s_if.done;
      a.to = s_if.timeout;
      a.cc = 16'(s_if.cycle_count);
      a.ri = s_if.run_index;
`ifdef RUN_CTRL_HALT_LOG_EN
      a.hr = s_if.halt_runs;
      a.ll = 16'(s_if.last_len);
`else
      e.hr = '0; e.ll = '0;
`endif
      check("sat", n_sat, a, e);
      n_sat++;
    end
  end

  initial begin
    int l0;
    int abort_cc;
    rst = 1'b1; rst_s = 1'b1;
    m_if.start = 1'b0; m_if.cpu_halt = 1'b0;
    s_if.start = 1'b0; s_if.cpu_halt = 1'b0;
    m_to = 0; m_hr = 0; m_ll = 0;

    repeat (3) edge_m(rb(), rb(), 1, idle_r());
    repeat (3) edge_m(0, rb(), 0, idle_r());

    plan = '{0, 0, 0};
    run_sequence(-1);
    plan = '{10, 10, 10};
    run_sequence(-1);
    plan = '{BUD, 1, BUD + 4};
    run_sequence(-1);
    plan = '{0, 0, 0};
    run_sequence(30);
    plan = '{5, 0, 10};
    run_sequence(-1);

    repeat (10) begin
      for (int r = 0; r < NR; r++) begin
        case ($urandom_range(0, 4))
          0: plan[r] = 0;
          1: plan[r] = 1;
          2: plan[r] = BUD;
          3: plan[r] = BUD + int'($urandom_range(1, 20));
          default: plan[r] = int'($urandom_range(2, BUD - 1));
        endcase
      end
      l0 = (plan[0] >= 1 && plan[0] <= BUD) ? plan[0] : BUD;
      abort_cc = -1;
      if ($urandom_range(0, 4) == 0)
        abort_cc = int'($urandom_range(0, l0 - 1));
      run_sequence(abort_cc);
    end

    repeat (2) edge_s(rb(), rb(), 1, idle_r());
    edge_s(0, rb(), 0, idle_r());
    edge_s(1, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    edge_s(rb(), rb(), 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    edge_s(rb(), rb(), 0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 40; k++)
      edge_s(rb(), 0, 0,
        mk(0, 1, 1, 0, 0, (k > 15) ? 15 : k, 0, 0, 0));
    edge_s(0, 1, 0, mk(0, 0, 0, 1, 0, 15, 0, 1, 15));
    repeat (2)
      edge_s(0, rb(), 0, mk(0, 0, 0, 1, 0, 15, 0, 1, 15));

    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL main_drain got %0d left, want 0",
        q.size());
    end
    n_tests++;
    if (q_s.size() != 0) begin
      n_fail++;
      $display("FAIL sat_drain got %0d left, want 0",
        q_s.size());
    end
    $display("[TB] %0d tests run, %0d failed",
      n_tests, n_fail);
    $finish;
  end

endmodule
